// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core front end: address width, fetch FSM
// states, special instruction encodings and a small PC arithmetic helper.
package cpu_pkg;

    localparam int ADDR_W = 32;

    localparam logic [31:0] NOP_WORD      = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // Next sequential word address; wraps modulo 2^32.
    function automatic logic [ADDR_W-1:0] word_inc(input logic [ADDR_W-1:0] addr);
        return addr + 32'd1;
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. load captures a new instruction, flush only drops
// the valid bit (payload fields are don't-care once invalid), otherwise hold.
module ifid_reg
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              flush,
    input  logic [31:0]       load_instr,
    input  logic [ADDR_W-1:0] load_pc,
    output logic              valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus1
);

    // Pipeline register update: load has priority over flush, default is hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            instr    <= NOP_WORD;
            pc       <= 32'd0;
            pc_plus1 <= 32'd0;
        end else if (load) begin
            valid    <= 1'b1;
            instr    <= load_instr;
            pc       <= load_pc;
            pc_plus1 <= word_inc(load_pc);
        end else if (flush) begin
            valid    <= 1'b0;
        end else begin
            valid    <= valid;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, boot/run/halt FSM, delivered
// instruction counter and sticky address-error flag; drives the IF/ID register.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'd0,
    parameter int unsigned       MEM_DEPTH = 512,
    parameter logic [31:0]       HALT_WORD = HALT_WORD_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    output logic              ifid_valid,
    output logic [31:0]       ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic [ADDR_W-1:0] ifid_pc_plus1,
    output logic              halted,
    output logic              addr_err,
    output logic [31:0]       fetch_count
);

    localparam logic [ADDR_W-1:0] MEM_DEPTH_W = ADDR_W'(MEM_DEPTH);

    fetch_state_t      state_r;
    logic [ADDR_W-1:0] pc_r;
    logic [31:0]       fetch_count_r;
    logic              addr_err_r;
    logic              halted_r;

    logic              addr_oob_s;
    logic              halt_hit_s;
    logic              load_s;
    logic              flush_s;

    assign addr_oob_s  = (pc_r >= MEM_DEPTH_W);
    assign halt_hit_s  = (imem_instr == HALT_WORD);

    assign imem_addr   = pc_r;
    assign halted      = halted_r;
    assign addr_err    = addr_err_r;
    assign fetch_count = fetch_count_r;

    // IF/ID control: decide load / flush / hold from state and fetch outcome.
    always_comb begin
        load_s  = 1'b0;
        flush_s = 1'b0;
        case (state_r)
            BOOT: begin
                load_s  = 1'b0;
                flush_s = 1'b0;
            end
            RUN: begin
                if (redirect_valid) begin
                    flush_s = 1'b1;
                end else if (stall) begin
                    flush_s = 1'b0;
                end else if (addr_oob_s || halt_hit_s) begin
                    flush_s = 1'b1;
                end else begin
                    load_s  = 1'b1;
                end
            end
            HALTED: begin
                if (redirect_valid) begin
                    flush_s = 1'b1;
                end else if (stall) begin
                    flush_s = 1'b0;
                end else begin
                    flush_s = 1'b1;
                end
            end
            default: begin
                flush_s = 1'b1;
            end
        endcase
    end

    // Fetch FSM with PC, counter, sticky address error and registered halted flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= BOOT;
            pc_r          <= RESET_PC;
            fetch_count_r <= 32'd0;
            addr_err_r    <= 1'b0;
            halted_r      <= 1'b0;
        end else begin
            case (state_r)
                BOOT: begin
                    state_r  <= RUN;
                    halted_r <= 1'b0;
                end
                RUN: begin
                    if (redirect_valid) begin
                        pc_r <= redirect_target;
                    end else if (stall) begin
                        pc_r <= pc_r;
                    end else if (addr_oob_s) begin
                        addr_err_r <= 1'b1;
                        state_r    <= HALTED;
                        halted_r   <= 1'b1;
                    end else if (halt_hit_s) begin
                        state_r    <= HALTED;
                        halted_r   <= 1'b1;
                    end else begin
                        pc_r          <= word_inc(pc_r);
                        fetch_count_r <= fetch_count_r + 32'd1;
                    end
                end
                HALTED: begin
                    if (redirect_valid) begin
                        pc_r     <= redirect_target;
                        state_r  <= RUN;
                        halted_r <= 1'b0;
                    end else begin
                        halted_r <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= BOOT;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    ifid_reg u_ifid_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load_s),
        .flush      (flush_s),
        .load_instr (imem_instr),
        .load_pc    (pc_r),
        .valid      (ifid_valid),
        .instr      (ifid_instr),
        .pc         (ifid_pc),
        .pc_plus1   (ifid_pc_plus1)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a behavioural model predicts each
// capture into a scoreboard queue, and scenario tasks add targeted checks.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus1;
    logic        halted;
    logic        addr_err;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:511];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;
    exp_t sb_q[$];

    int errors = 0;
    int checks = 0;

    // bench model state: 0 boot, 1 run, 2 halted
    int          m_state;
    logic [31:0] m_pc;
    logic [31:0] m_count;
    logic        m_err;
    logic        m_valid;

    fetch_stage #(
        .RESET_PC  (32'd0),
        .MEM_DEPTH (512),
        .HALT_WORD (32'hFFFF_FFFF)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .ifid_valid      (ifid_valid),
        .ifid_instr      (ifid_instr),
        .ifid_pc         (ifid_pc),
        .ifid_pc_plus1   (ifid_pc_plus1),
        .halted          (halted),
        .addr_err        (addr_err),
        .fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_at(input logic [31:0] a);
        if (a < 32'd512) return mem[a[8:0]];
        return 32'hDEAD_BEEF;
    endfunction

    assign imem_instr = mem_at(imem_addr);

    task automatic model_reset();
        m_state = 0;
        m_pc    = 32'd0;
        m_count = 32'd0;
        m_err   = 1'b0;
        m_valid = 1'b0;
        sb_q.delete();
    endtask

    // One clock of stimulus: update model, push predicted capture, then compare.
    task automatic drive(input logic st, input logic rv, input logic [31:0] tgt);
        logic cap;
        exp_t e;
        exp_t got;
        cap = 1'b0;
        stall = st;
        redirect_valid = rv;
        redirect_target = tgt;
        case (m_state)
            0: m_state = 1;
            1: begin
                if (rv) begin
                    m_pc = tgt; m_valid = 1'b0;
                end else if (st) begin
                    m_valid = m_valid;
                end else if (m_pc >= 32'd512) begin
                    m_valid = 1'b0; m_err = 1'b1; m_state = 2;
                end else if (mem_at(m_pc) == 32'hFFFF_FFFF) begin
                    m_valid = 1'b0; m_state = 2;
                end else begin
                    e.instr = mem_at(m_pc);
                    e.pc = m_pc;
                    sb_q.push_back(e);
                    cap = 1'b1;
                    m_pc = m_pc + 32'd1;
                    m_count = m_count + 32'd1;
                    m_valid = 1'b1;
                end
            end
            default: begin
                if (rv) begin
                    m_state = 1; m_pc = tgt; m_valid = 1'b0;
                end else if (!st) begin
                    m_valid = 1'b0;
                end
            end
        endcase
        @(posedge clk);
        @(negedge clk);
        stall = 1'b0;
        redirect_valid = 1'b0;
        checks++;
        if (imem_addr !== m_pc) begin errors++; $display("FAIL sb_imem_addr got=%h exp=%h", imem_addr, m_pc); end
        checks++;
        if (ifid_valid !== m_valid) begin errors++; $display("FAIL sb_ifid_valid got=%b exp=%b", ifid_valid, m_valid); end
        checks++;
        if (halted !== (m_state == 2)) begin errors++; $display("FAIL sb_halted got=%b exp=%b", halted, (m_state == 2)); end
        checks++;
        if (addr_err !== m_err) begin errors++; $display("FAIL sb_addr_err got=%b exp=%b", addr_err, m_err); end
        checks++;
        if (fetch_count !== m_count) begin errors++; $display("FAIL sb_fetch_count got=%0d exp=%0d", fetch_count, m_count); end
        if (cap) begin
            got = sb_q.pop_front();
            checks++;
            if (ifid_instr !== got.instr) begin errors++; $display("FAIL sb_instr got=%h exp=%h", ifid_instr, got.instr); end
            checks++;
            if (ifid_pc !== got.pc) begin errors++; $display("FAIL sb_pc got=%h exp=%h", ifid_pc, got.pc); end
            checks++;
            if (ifid_pc_plus1 !== got.pc + 32'd1) begin errors++; $display("FAIL sb_pc_plus1 got=%h exp=%h", ifid_pc_plus1, got.pc + 32'd1); end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'd0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (imem_addr !== 32'd0) begin errors++; $display("FAIL reset_imem_addr got=%h exp=0", imem_addr); end
        checks++;
        if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ifid_valid); end
        checks++;
        if ({ifid_instr, ifid_pc, ifid_pc_plus1} !== 96'd0) begin errors++; $display("FAIL reset_ifid got=%h/%h/%h exp=0", ifid_instr, ifid_pc, ifid_pc_plus1); end
        checks++;
        if ({halted, addr_err} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", halted, addr_err); end
        checks++;
        if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
        rst_n = 1'b1;
    endtask

    task automatic test_boot_fetch();
        drive(1'b0, 1'b0, 32'd0);
        checks++;
        if (imem_addr !== 32'd0) begin errors++; $display("FAIL boot_imem_addr got=%h exp=0", imem_addr); end
        drive(1'b0, 1'b0, 32'd0);
        checks++;
        if (ifid_instr !== 32'h2231_0000 || ifid_pc !== 32'd0 || ifid_pc_plus1 !== 32'd1) begin
            errors++; $display("FAIL first_fetch got=%h pc=%h pc1=%h exp=22310000 pc=0 pc1=1", ifid_instr, ifid_pc, ifid_pc_plus1);
        end
        drive(1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 32'd0);
    endtask

    task automatic test_stall();
        checks++;
        if (ifid_pc !== 32'd2 || ifid_instr !== 32'h2008_004b) begin errors++; $display("FAIL pre_stall got=%h pc=%h exp=2008004b pc=2", ifid_instr, ifid_pc); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'd0);
            checks++;
            if (ifid_instr !== 32'h2008_004b || imem_addr !== 32'd3 || fetch_count !== 32'd3) begin
                errors++; $display("FAIL stall_hold got=%h addr=%h cnt=%0d exp=2008004b addr=3 cnt=3", ifid_instr, imem_addr, fetch_count);
            end
        end
        drive(1'b0, 1'b0, 32'd0);
        checks++;
        if (ifid_pc !== 32'd3 || fetch_count !== 32'd4) begin errors++; $display("FAIL stall_resume got pc=%h cnt=%0d exp pc=3 cnt=4", ifid_pc, fetch_count); end
    endtask

    task automatic test_halt();
        drive(1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 32'd0);
        checks++;
        if (halted !== 1'b1 || imem_addr !== 32'd5 || ifid_valid !== 1'b0 || fetch_count !== 32'd5) begin
            errors++; $display("FAIL halt_state got h=%b addr=%h v=%b cnt=%0d exp h=1 addr=5 v=0 cnt=5", halted, imem_addr, ifid_valid, fetch_count);
        end
        drive(1'b1, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b1, 32'd0);
        checks++;
        if (halted !== 1'b0) begin errors++; $display("FAIL halt_release got=%b exp=0", halted); end
        drive(1'b0, 1'b0, 32'd0);
        checks++;
        if (ifid_pc !== 32'd0 || ifid_valid !== 1'b1) begin errors++; $display("FAIL halt_refetch got pc=%h v=%b exp pc=0 v=1", ifid_pc, ifid_valid); end
    endtask

    task automatic test_redirect_priority();
        drive(1'b1, 1'b1, 32'd7);
        checks++;
        if (ifid_valid !== 1'b0 || imem_addr !== 32'd7) begin errors++; $display("FAIL redirect_flush got v=%b addr=%h exp v=0 addr=7", ifid_valid, imem_addr); end
        drive(1'b0, 1'b0, 32'd0);
        checks++;
        if (ifid_pc !== 32'd7 || ifid_instr !== 32'h0109_5020) begin errors++; $display("FAIL redirect_target got pc=%h i=%h exp pc=7 i=01095020", ifid_pc, ifid_instr); end
    endtask

    task automatic test_addr_err();
        drive(1'b0, 1'b1, 32'd512);
        drive(1'b0, 1'b0, 32'd0);
        checks++;
        if (addr_err !== 1'b1 || halted !== 1'b1 || ifid_valid !== 1'b0) begin
            errors++; $display("FAIL addr_fault got e=%b h=%b v=%b exp e=1 h=1 v=0", addr_err, halted, ifid_valid);
        end
        drive(1'b0, 1'b1, 32'd0);
        drive(1'b0, 1'b0, 32'd0);
        checks++;
        if (addr_err !== 1'b1 || halted !== 1'b0 || ifid_pc !== 32'd0) begin
            errors++; $display("FAIL addr_resume got e=%b h=%b pc=%h exp e=1 h=0 pc=0", addr_err, halted, ifid_pc);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (addr_err !== 1'b0 || halted !== 1'b0 || ifid_valid !== 1'b0 || fetch_count !== 32'd0 || imem_addr !== 32'd0) begin
            errors++; $display("FAIL async_reset got e=%b h=%b v=%b cnt=%0d addr=%h exp all 0", addr_err, halted, ifid_valid, fetch_count, imem_addr);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 32'd0);
        checks++;
        if (ifid_pc !== 32'd0 || fetch_count !== 32'd1) begin errors++; $display("FAIL post_reset got pc=%h cnt=%0d exp pc=0 cnt=1", ifid_pc, fetch_count); end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'd0;
        mem[0] = 32'h2231_0000;
        mem[1] = 32'h0000_0000;
        mem[2] = 32'h2008_004b;
        mem[3] = 32'h014a_6020;
        mem[4] = 32'h8c09_0004;
        mem[5] = 32'hFFFF_FFFF;
        mem[7] = 32'h0109_5020;
        mem[8] = 32'hac0a_0008;

        test_reset();
        test_boot_fetch();
        test_stall();
        test_halt();
        test_redirect_priority();
        test_addr_err();

        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size()); end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
